// File: rtl/apuf_response_collector.sv
// Arbiter-PUF controller: drives LFSR challenges into a 16-stage chain and shifts
// KEY_W response bits into a key register. Optional macro: APUF_MAJORITY_VOTE_EN.
module apuf_response_collector #(
    parameter int KEY_W      = 128,
    parameter int SETTLE_CYC = 4,
    parameter int EVAL_CYC   = 8,
    parameter int VOTES      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      seed,
    output logic [0:15]      challenge,
    output logic             puf_in,
    output logic             puf_reset,
    input  logic             puf_out,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             busy
);

    localparam int MAX_CYC = (SETTLE_CYC > EVAL_CYC) ? SETTLE_CYC : EVAL_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int BIT_W   = $clog2(KEY_W) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, WAIT, SHIFT, DONE} state_t;

    state_t           state;
    logic [1:0]       sync_q;
    logic             resp_s;
    logic             sample_bit;
    logic [CNT_W-1:0] cyc_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             fb;

    assign resp_s = sync_q[1];
    assign fb     = challenge[15] ^ challenge[13] ^ challenge[12] ^ challenge[10];

`ifdef APUF_MAJORITY_VOTE_EN
    logic [3:0] vote_idx;
    logic [3:0] ones;
    logic [4:0] vote_sum;
    assign vote_sum = {1'b0, ones} + {4'b0, resp_s};
`endif

    // puf_out is launched by puf_in and settles with no relation to clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], puf_out};
    end

    // NOTE: puf_in/puf_reset are registered on entry to each state so they hold steady for the whole state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            challenge  <= '0;
            puf_in     <= 1'b0;
            puf_reset  <= 1'b1;
            key        <= '0;
            key_valid  <= 1'b0;
            busy       <= 1'b0;
            bit_cnt    <= '0;
            cyc_cnt    <= '0;
            sample_bit <= 1'b0;
`ifdef APUF_MAJORITY_VOTE_EN
            vote_idx   <= '0;
            ones       <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) state <= LOAD;
                LOAD: begin
                    challenge <= (seed == 16'h0000) ? 16'hACE1 : seed;
                    bit_cnt   <= '0;
                    cyc_cnt   <= '0;
                    key       <= '0;
                    key_valid <= 1'b0;
                    busy      <= 1'b1;
                    puf_reset <= 1'b1;
                    puf_in    <= 1'b0;
`ifdef APUF_MAJORITY_VOTE_EN
                    vote_idx  <= '0;
                    ones      <= '0;
`endif
                    state     <= CLEAR;
                end
                CLEAR: begin
                    if (cyc_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        cyc_cnt   <= '0;
                        puf_reset <= 1'b0;
                        puf_in    <= 1'b1;
                        state     <= WAIT;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (cyc_cnt == CNT_W'(EVAL_CYC - 1)) begin
                        cyc_cnt   <= '0;
                        puf_in    <= 1'b0;
                        puf_reset <= 1'b1;
`ifdef APUF_MAJORITY_VOTE_EN
                        if (vote_idx == 4'(VOTES - 1)) begin
                            sample_bit <= (vote_sum > 5'(VOTES / 2));
                            state      <= SHIFT;
                        end else begin
                            ones     <= vote_sum[3:0];
                            vote_idx <= vote_idx + 1'b1;
                            state    <= CLEAR;
                        end
`else
                        sample_bit <= resp_s;
                        state      <= SHIFT;
`endif
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    key       <= {key[KEY_W-2:0], sample_bit};
                    bit_cnt   <= bit_cnt + 1'b1;
                    challenge <= {challenge[1:15], fb};
`ifdef APUF_MAJORITY_VOTE_EN
                    vote_idx  <= '0;
                    ones      <= '0;
`endif
                    state     <= (bit_cnt == BIT_W'(KEY_W - 1)) ? DONE : CLEAR;
                end
                DONE: begin
                    key_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apuf_response_collector.sv
// Randomized bench for apuf_response_collector against a behavioural LFSR/key model.
module tb_apuf_response_collector;

    localparam int KEY_W      = 128;
    localparam int SETTLE_CYC = 4;
    localparam int EVAL_CYC   = 8;
    localparam int VOTES      = 5;
`ifdef APUF_MAJORITY_VOTE_EN
    localparam int BIT_CYC = VOTES * (SETTLE_CYC + EVAL_CYC) + 1;
`else
    localparam int BIT_CYC = SETTLE_CYC + EVAL_CYC + 1;
`endif
    localparam int LAT = 2 + KEY_W * BIT_CYC;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [15:0]      seed = '0;
    logic [0:15]      challenge;
    logic             puf_in, puf_reset, puf_out;
    logic [KEY_W-1:0] key;
    logic             key_valid, busy;

    // Behavioural PUF: response follows challenge[0], optionally inverted or noisy
    logic tie_one = 1'b0, inv = 1'b0, noise = 1'b0, noise_en = 1'b0;
    int   eval_cnt = 0, noise_off = 0;

    int n_checks = 0, n_fail = 0;

    apuf_response_collector #(
        .KEY_W(KEY_W), .SETTLE_CYC(SETTLE_CYC), .EVAL_CYC(EVAL_CYC), .VOTES(VOTES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .challenge(challenge), .puf_in(puf_in), .puf_reset(puf_reset),
        .puf_out(puf_out), .key(key), .key_valid(key_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb puf_out = tie_one | (challenge[0] ^ inv ^ noise);

    always @(posedge puf_in) begin
        noise = noise_en && (((eval_cnt + noise_off) % VOTES) < 2);
        eval_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Challenge held as an array indexed by chain stage; packed with stage 0 at the MSB
    function automatic logic [15:0] pack(input logic c[16]);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = c[i];
        return w;
    endfunction

    task automatic model_run(input logic [15:0] s, input logic all_one, input logic invert,
                             output logic [127:0] exp_key, output logic [15:0] ch_first,
                             output logic [15:0] ch_second);
        logic c[16];
        logic f;
        logic [15:0] s_eff;
        s_eff   = (s == 16'h0000) ? 16'hACE1 : s;
        exp_key = '0;
        for (int i = 0; i < 16; i++) c[i] = s_eff[15-i];
        ch_first  = pack(c);
        ch_second = '0;
        for (int k = 0; k < KEY_W; k++) begin
            exp_key[KEY_W-1-k] = all_one ? 1'b1 : (c[0] ^ invert);
            f = c[15] ^ c[13] ^ c[12] ^ c[10];
            for (int i = 0; i < 15; i++) c[i] = c[i+1];
            c[15] = f;
            if (k == 0) ch_second = pack(c);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_challenge"}, 128'(challenge), 128'h0);
        check({tag, "_puf_reset"}, 128'(puf_reset), 128'h1);
        check({tag, "_puf_in"},    128'(puf_in),    128'h0);
        check({tag, "_key"},       key,             128'h0);
        check({tag, "_key_valid"}, 128'(key_valid), 128'h0);
        check({tag, "_busy"},      128'(busy),      128'h0);
    endtask

    // Full run from IDLE; optional ignored start pulse during bit pulse_bit
    task automatic run_and_check(input string tag, input logic [15:0] s, input logic all_one,
                                 input logic invert, input int pulse_bit);
        logic [127:0] exp_key;
        logic [15:0]  exp_c1, exp_c2, got_c1, got_c2;
        logic         busy_prev;
        int           edge_n;
        model_run(s, all_one, invert, exp_key, exp_c1, exp_c2);
        seed = s; tie_one = all_one; inv = invert; eval_cnt = 0;
        got_c1 = '0; got_c2 = '0; busy_prev = 1'b0; edge_n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (edge_n < LAT + 50) begin
            busy_prev = busy;
            tick();
            edge_n++;
            start = (pulse_bit >= 0 && edge_n == 2 + pulse_bit * BIT_CYC + 3);
            if (edge_n == 1) got_c1 = challenge;
            if (edge_n == 1 + BIT_CYC) got_c2 = challenge;
            if (key_valid) break;
        end
        start = 1'b0;
        check({tag, "_latency"},    128'(edge_n),    128'(LAT));
        check({tag, "_busy_low"},   128'(busy),      128'h0);
        check({tag, "_busy_prev"},  128'(busy_prev), 128'h1);
        check({tag, "_key"},        key,             exp_key);
        check({tag, "_challenge1"}, 128'(got_c1),    128'(exp_c1));
        check({tag, "_challenge2"}, 128'(got_c2),    128'(exp_c2));
        repeat (3) tick();
        check({tag, "_valid_held"}, 128'(key_valid), 128'h1);
        check({tag, "_key_held"},   key,             exp_key);
    endtask

    initial begin
        logic [15:0] rs;
        reset = 1'b1;
        repeat (3) tick();
        check_reset_state("reset_hold");
        reset = 1'b0;
        tick();

        run_and_check("ones", 16'h0001, 1'b1, 1'b0, -1);
        run_and_check("seed0", 16'h0000, 1'b0, 1'b0, -1);
        run_and_check("seed1234", 16'h1234, 1'b0, 1'($urandom_range(1)), -1);

        rs = 16'($urandom);
        run_and_check("start_pulse", rs, 1'b0, 1'b0, 10);

        // Abort part-way through bit 40, then a clean run must still be exact
        seed = 16'($urandom); tie_one = 1'b0; inv = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2 + 40 * BIT_CYC + 5) tick();
        check("midrun_busy", 128'(busy), 128'h1);
        #2 reset = 1'b1;
        #1 check_reset_state("midrun_reset");
        tick();
        check_reset_state("midrun_reset_held");
        reset = 1'b0;
        tick();
        rs = 16'($urandom);
        run_and_check("after_reset", rs, 1'b0, 1'b1, -1);

`ifdef APUF_MAJORITY_VOTE_EN
        noise_en = 1'b1;
        noise_off = $urandom_range(VOTES - 1);
        rs = 16'($urandom);
        run_and_check("vote_noise", rs, 1'b0, 1'b0, -1);
        noise_en = 1'b0;
        noise = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
